// File: rtl/flit_out_sched_pkg.sv
// Shared constants and FSM encoding for the flit output scheduler.
package flit_out_sched_pkg;

  // Timestamp / time-difference width used throughout the router model.
  localparam int unsigned TS_WIDTH = 8;

  // Default scheduler geometry.
  localparam int unsigned N_DEFAULT     = 4;
  localparam int unsigned IDX_W_DEFAULT = 2;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StOffer = 1'b1
  } sched_state_e;

endpackage

// File: rtl/flit_out_sched_if.sv
// Queue-side and downstream-side handshake bundle of the flit output scheduler.
interface flit_out_sched_if
  import flit_out_sched_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned TS_W  = TS_WIDTH,
  parameter int unsigned IDX_W = IDX_W_DEFAULT
);

  logic [N-1:0]      in_valid;
  logic [N*TS_W-1:0] in_timestamp;
  logic [N-1:0]      in_dequeue;
  logic              out_valid;
  logic [IDX_W-1:0]  out_sel;
  logic [TS_W-1:0]   out_timestamp;
  logic              out_ack;

  // Scheduler side.
  modport master (
    input  in_valid,
    input  in_timestamp,
    output in_dequeue,
    output out_valid,
    output out_sel,
    output out_timestamp,
    input  out_ack
  );

  // Queues plus downstream consumer side.
  modport slave (
    output in_valid,
    output in_timestamp,
    input  in_dequeue,
    input  out_valid,
    input  out_sel,
    input  out_timestamp,
    output out_ack
  );

endinterface

// File: rtl/flit_due_track.sv
// Per-queue due tracking: time difference, wrap-safe sticky readiness and age.
module flit_due_track
  import flit_out_sched_pkg::*;
#(
  parameter int unsigned TS_W = TS_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [TS_W-1:0] sim_time,
  input  logic            valid,
  input  logic [TS_W-1:0] timestamp,
  input  logic            dequeue,
  output logic            rdy,
  output logic [TS_W:0]   age
);

  logic [TS_W-1:0] diff;
  logic            w_rdy;
  logic            s_rdy_q, s_rdy_d;

  // Due test on the modular difference; MSB set means "in the future".
  always_comb begin
    diff  = sim_time - timestamp;
    w_rdy = valid & ~diff[TS_W-1];
  end

  // Sticky ready remembers a due head once diff wraps; dequeue or empty clears it.
  always_comb begin
    s_rdy_d = s_rdy_q | w_rdy;
    if (!valid || dequeue) begin
      s_rdy_d = 1'b0;
    end
  end

  // Readiness and comparison age; a wrapped sticky head saturates as oldest.
  always_comb begin
    // Gate sticky with valid so an emptied queue never wins in its drop cycle.
    rdy = w_rdy | (s_rdy_q & valid);
    age = '0;
    if (w_rdy) begin
      age = {1'b0, diff};
    end else if (s_rdy_q) begin
      age = {1'b1, {TS_W{1'b0}}};
    end
  end

  // Sticky ready register.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_rdy_q <= 1'b0;
    end else begin
      s_rdy_q <= s_rdy_d;
    end
  end

endmodule

// File: rtl/flit_out_sched.sv
// Oldest-first, round-robin tie-broken output scheduler over N flit queues.
module flit_out_sched
  import flit_out_sched_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned TS_W  = TS_WIDTH,
  parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TS_W-1:0]   sim_time,
  flit_out_sched_if.master  bus,
  output logic              err_lost
);

  logic [N-1:0]     rdy;
  logic [TS_W:0]    age [N];
  logic [N-1:0]     deq;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [TS_W:0]    win_age;
  logic [TS_W-1:0]  ts_winner;

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] out_sel_q, out_sel_d;
  logic [TS_W-1:0]  out_ts_q, out_ts_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             err_q, err_d;

  for (genvar i = 0; i < N; i++) begin : g_track
    flit_due_track #(
      .TS_W(TS_W)
    ) u_track (
      .clock    (clock),
      .reset    (reset),
      .sim_time (sim_time),
      .valid    (bus.in_valid[i]),
      .timestamp(bus.in_timestamp[i*TS_W +: TS_W]),
      .dequeue  (deq[i]),
      .rdy      (rdy[i]),
      .age      (age[i])
    );
  end

  // Scan from rr onward; strict '>' keeps the earliest index in rr order on ties.
  always_comb begin
    logic [IDX_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_age   = '0;
    idx       = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = IDX_W'((int'(rr_q) + k) % int'(N));
      if (rdy[idx] && (!win_found || (age[idx] > win_age))) begin
        win_found = 1'b1;
        win_idx   = idx;
        win_age   = age[idx];
      end
    end
    ts_winner = bus.in_timestamp[int'(win_idx)*TS_W +: TS_W];
  end

  // Offer FSM: latch winner in idle, hold the offer until ack or loss.
  always_comb begin
    state_d   = state_q;
    out_sel_d = out_sel_q;
    out_ts_d  = out_ts_q;
    rr_d      = rr_q;
    err_d     = err_q;
    deq       = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          out_sel_d = win_idx;
          out_ts_d  = ts_winner;
          state_d   = StOffer;
        end
      end
      StOffer: begin
        if (bus.out_ack) begin
          // Ack wins over a same-cycle valid drop; reset suppresses the pop.
          deq[out_sel_q] = ~reset;
          rr_d           = (out_sel_q == IDX_W'(N - 1)) ? '0 : out_sel_q + 1'b1;
          state_d        = StIdle;
        end else if (!bus.in_valid[out_sel_q]) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, offer and pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      out_sel_q <= '0;
      out_ts_q  <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_sel_q <= out_sel_d;
      out_ts_q  <= out_ts_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_dequeue    = deq;
  assign bus.out_valid     = (state_q == StOffer);
  assign bus.out_sel       = out_sel_q;
  assign bus.out_timestamp = out_ts_q;
  assign err_lost          = err_q;

endmodule

// File: tb/tb_flit_out_sched.sv
// Self-checking bench for flit_out_sched (N=4, TS_W=8).
module tb_flit_out_sched;

  logic       clock;
  logic       reset;
  logic [7:0] sim_time;
  logic       err_lost;

  int n_checks;
  int n_fail;

  flit_out_sched_if #(.N(4), .TS_W(8), .IDX_W(2)) bus ();

  flit_out_sched #(
    .N    (4),
    .TS_W (8),
    .IDX_W(2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .sim_time(sim_time),
    .bus     (bus),
    .err_lost(err_lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic [7:0]  st;
    logic [3:0]  valid;
    logic [31:0] ts;      // {q3, q2, q1, q0}
    logic        exp_valid;
    logic [1:0]  exp_sel;
    logic [7:0]  exp_ts;
  } vec_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] ts;
    logic [3:0] deq;
  } exp_t;

  vec_t vecs [11];
  exp_t sb [$];

  function automatic vec_t mkv(input logic rst, input logic [7:0] st, input logic [3:0] valid,
                               input logic [31:0] ts, input logic ev, input logic [1:0] es,
                               input logic [7:0] ets);
    vec_t v;
    v.rst = rst; v.st = st; v.valid = valid; v.ts = ts;
    v.exp_valid = ev; v.exp_sel = es; v.exp_ts = ets;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_offer(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = '0;
    bus.out_ack = 1'b0;
    next_cyc();
    next_cyc();
    reset = 1'b0;
  endtask

  // Called at a negedge while an offer is up: ack it and check the dequeue pulse.
  task automatic accept(input string name, input logic [3:0] exp_deq);
    bus.out_ack = 1'b1;
    #1;
    chk(name, bus.in_dequeue, exp_deq);
    next_cyc();
    bus.out_ack = 1'b0;
  endtask

  initial begin
    bit   seen;
    exp_t e;
    int   hold_bad;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = mkv(1, 8'd10, 4'b1111, {8'd10, 8'd8, 8'd5, 8'd12}, 1, 2'd1, 8'd5);
    vecs[1]  = mkv(0, 8'd10, 4'b1101, {8'd10, 8'd8, 8'd5, 8'd12}, 1, 2'd2, 8'd8);
    vecs[2]  = mkv(0, 8'd10, 4'b1001, {8'd10, 8'd8, 8'd5, 8'd12}, 1, 2'd3, 8'd10);
    vecs[3]  = mkv(0, 8'd10, 4'b0001, {8'd10, 8'd8, 8'd5, 8'd12}, 0, 2'd0, 8'd0);
    vecs[4]  = mkv(0, 8'd11, 4'b0001, {8'd10, 8'd8, 8'd5, 8'd12}, 0, 2'd0, 8'd0);
    vecs[5]  = mkv(0, 8'd12, 4'b0001, {8'd10, 8'd8, 8'd5, 8'd12}, 1, 2'd0, 8'd12);
    vecs[6]  = mkv(1, 8'd7,  4'b1111, {8'd7, 8'd7, 8'd7, 8'd7},   1, 2'd0, 8'd7);
    vecs[7]  = mkv(0, 8'd7,  4'b1111, {8'd7, 8'd7, 8'd7, 8'd7},   1, 2'd1, 8'd7);
    vecs[8]  = mkv(0, 8'd7,  4'b1111, {8'd7, 8'd7, 8'd7, 8'd7},   1, 2'd2, 8'd7);
    vecs[9]  = mkv(0, 8'd7,  4'b1111, {8'd7, 8'd7, 8'd7, 8'd7},   1, 2'd3, 8'd7);
    vecs[10] = mkv(0, 8'd7,  4'b1111, {8'd7, 8'd7, 8'd7, 8'd7},   1, 2'd0, 8'd7);

    // Reset with everything due: outputs quiet during reset, q0 first afterwards.
    reset = 1'b1;
    sim_time = 8'd0;
    bus.in_valid = 4'b1111;
    bus.in_timestamp = '0;
    bus.out_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_dequeue", bus.in_dequeue, 0);
      chk("rst_err_lost", err_lost, 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_offer(2, seen);
    chk("rst_first_offer", seen, 1);
    chk("rst_first_sel", bus.out_sel, 0);
    chk("rst_first_ts", bus.out_timestamp, 0);
    if (seen) accept("rst_first_deq", 4'b0001);

    // Table-driven oldest-first and tie-break vectors through the scoreboard.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst) do_reset();
      sim_time = vecs[i].st;
      bus.in_valid = vecs[i].valid;
      bus.in_timestamp = vecs[i].ts;
      if (vecs[i].exp_valid) begin
        e.sel = vecs[i].exp_sel;
        e.ts  = vecs[i].exp_ts;
        e.deq = 4'b0001 << vecs[i].exp_sel;
        sb.push_back(e);
        wait_offer(4, seen);
        chk($sformatf("vec%0d_offer", i), seen, 1);
        e = sb.pop_front();
        if (seen) begin
          chk($sformatf("vec%0d_sel", i), bus.out_sel, e.sel);
          chk($sformatf("vec%0d_ts", i), bus.out_timestamp, e.ts);
          accept($sformatf("vec%0d_deq", i), e.deq);
        end else begin
          next_cyc();
        end
      end else begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clock);
          chk($sformatf("vec%0d_no_offer", i), bus.out_valid, 0);
        end
        next_cyc();
      end
    end

    // Hold and sticky: offer stays put while sim_time runs past the diff wrap.
    do_reset();
    sim_time = 8'd3;
    bus.in_valid = 4'b0100;
    bus.in_timestamp = {8'd0, 8'd3, 8'd0, 8'd0};
    wait_offer(4, seen);
    chk("hold_offer", seen, 1);
    chk("hold_sel", bus.out_sel, 2);
    chk("hold_ts", bus.out_timestamp, 3);
    hold_bad = 0;
    for (int c = 0; c < 200; c++) begin
      next_cyc();
      sim_time = sim_time + 8'd1;
      @(negedge clock);
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_timestamp !== 8'd3 ||
          bus.in_dequeue !== 4'b0000) hold_bad++;
    end
    chk("hold_stable_cycles_bad", hold_bad, 0);
    accept("hold_deq", 4'b0100);

    // Lost flit: offered queue empties without ack.
    do_reset();
    sim_time = 8'd0;
    bus.in_valid = 4'b0010;
    bus.in_timestamp = '0;
    wait_offer(4, seen);
    chk("lost_offer", seen, 1);
    chk("lost_sel", bus.out_sel, 1);
    next_cyc();
    bus.in_valid = 4'b0000;
    @(negedge clock);
    chk("lost_no_deq", bus.in_dequeue, 0);
    @(negedge clock);
    chk("lost_out_valid", bus.out_valid, 0);
    chk("lost_err", err_lost, 1);
    bus.out_ack = 1'b1;
    #1;
    chk("ack_idle_ignored", bus.in_dequeue, 0);
    bus.out_ack = 1'b0;
    for (int c = 0; c < 5; c++) next_cyc();
    @(negedge clock);
    chk("lost_err_sticky", err_lost, 1);
    do_reset();
    @(negedge clock);
    chk("lost_err_cleared", err_lost, 0);

    // Reset in the middle of an offer with ack asserted.
    do_reset();
    sim_time = 8'd0;
    bus.in_valid = 4'b1111;
    bus.in_timestamp = '0;
    wait_offer(4, seen);
    chk("rmo_first_sel", bus.out_sel, 0);
    if (seen) accept("rmo_first_deq", 4'b0001);
    wait_offer(4, seen);
    chk("rmo_second_offer", seen, 1);
    chk("rmo_second_sel", bus.out_sel, 1);
    reset = 1'b1;
    bus.out_ack = 1'b1;
    #1;
    chk("rmo_no_deq", bus.in_dequeue, 0);
    @(negedge clock);
    chk("rmo_out_valid", bus.out_valid, 0);
    chk("rmo_no_deq_after", bus.in_dequeue, 0);
    reset = 1'b0;
    bus.out_ack = 1'b0;
    wait_offer(4, seen);
    chk("rmo_restart_offer", seen, 1);
    chk("rmo_restart_sel", bus.out_sel, 0);
    if (seen) accept("rmo_restart_deq", 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
